// File: rtl/mem_port_arbiter_if.sv
// Request/ack bundle for the three memory requesters plus the shared single-port memory.
// slave = arbiter side, master = requesters and memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ack;
    logic [DATA_W-1:0] ext_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic [1:0]        grant_id;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, grant_id
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, grant_id
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch, data and external ports (dm > if > ext, ext promoted when starved).
// Latency: strobe WAIT_CYCLES+1 cycles after an IDLE request, ack one cycle later; requesters hold req until ack.
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 0,
    parameter int EXT_MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_IF   = 2'd1;
    localparam logic [1:0] G_DM   = 2'd2;
    localparam logic [1:0] G_EXT  = 2'd3;

    localparam logic [3:0] WAIT_LD    = 4'(WAIT_CYCLES);
    localparam logic [7:0] STARVE_MAX = 8'(EXT_MAX_WAIT);

    state_t            state_q, state_d;
    logic [1:0]        owner_q;
    logic [1:0]        pick;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt_q;
    logic [7:0]        starve_q;
    logic [DATA_W-1:0] if_rd_q, dm_rd_q, ext_rd_q;
    logic              any_req;
    logic              strobe;
    logic              resp;

    always_comb begin
        pick = G_NONE;
        if (bus.ext_req && (starve_q == STARVE_MAX)) pick = G_EXT;
        else if (bus.dm_req)                         pick = G_DM;
        else if (bus.if_req)                         pick = G_IF;
        else if (bus.ext_req)                        pick = G_EXT;
    end

    assign any_req = (pick != G_NONE);

    always_comb begin
        state_d = state_q;
        strobe  = 1'b0;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    strobe  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= G_NONE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 4'd0;
            starve_q <= 8'd0;
            if_rd_q  <= '0;
            dm_rd_q  <= '0;
            ext_rd_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= pick;
                        cnt_q   <= WAIT_LD;
                        case (pick)
                            G_IF: begin
                                addr_q  <= bus.if_addr;
                                we_q    <= 1'b0;
                                wdata_q <= '0;
                            end
                            G_DM: begin
                                addr_q  <= bus.dm_addr;
                                we_q    <= bus.dm_we;
                                wdata_q <= bus.dm_wdata;
                            end
                            default: begin
                                addr_q  <= bus.ext_addr;
                                we_q    <= bus.ext_we;
                                wdata_q <= bus.ext_wdata;
                            end
                        endcase
                        // ext only ages when it actually loses an arbitration
                        if (pick == G_EXT)
                            starve_q <= 8'd0;
                        else if (bus.ext_req && (starve_q != STARVE_MAX))
                            starve_q <= starve_q + 8'd1;
                    end
                end
                ACCESS: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                RESP: begin
                    if (!we_q) begin
                        case (owner_q)
                            G_IF:    if_rd_q  <= bus.mem_rdata;
                            G_DM:    dm_rd_q  <= bus.mem_rdata;
                            G_EXT:   ext_rd_q <= bus.mem_rdata;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // mem_rdata is forwarded during the ack cycle and captured for the hold afterwards
    assign resp          = (state_q == RESP);
    assign bus.if_ack    = resp && (owner_q == G_IF);
    assign bus.dm_ack    = resp && (owner_q == G_DM);
    assign bus.ext_ack   = resp && (owner_q == G_EXT);
    assign bus.if_rdata  = (bus.if_ack  && !we_q) ? bus.mem_rdata : if_rd_q;
    assign bus.dm_rdata  = (bus.dm_ack  && !we_q) ? bus.mem_rdata : dm_rd_q;
    assign bus.ext_rdata = (bus.ext_ack && !we_q) ? bus.mem_rdata : ext_rd_q;

    assign bus.mem_en    = strobe;
    assign bus.mem_we    = strobe && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = (state_q != IDLE) ? owner_q : G_NONE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table and sequences on two configurations, then
// random traffic against a transaction-level schedule model.
module tb_mem_port_arbiter;
    localparam int AW = 10, DW = 32;
    localparam int WA = 0, MA = 2;
    localparam int WB = 3, MB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, rst_b;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA), .EXT_MAX_WAIT(MA))
        dut_a (.clk(clk), .rst(rst_a), .bus(ia));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WB), .EXT_MAX_WAIT(MB))
        dut_b (.clk(clk), .rst(rst_b), .bus(ib));

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // memories behind each arbiter: one-cycle read latency
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    bit          mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
            mem_a[4]  <= 32'h3C010001;
            mem_ready <= 1'b1;
        end else begin
            if (ia.mem_en) begin
                if (ia.mem_we) mem_a[ia.mem_addr] <= ia.mem_wdata;
                else           ia.mem_rdata <= mem_a[ia.mem_addr];
            end
            if (ib.mem_en) begin
                if (ib.mem_we) mem_b[ib.mem_addr] <= ib.mem_wdata;
                else           ib.mem_rdata <= mem_b[ib.mem_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input int id, input logic v, input logic we,
                           input logic [9:0] addr, input logic [31:0] wd);
        case (id)
            1: begin ia.if_req = v; ia.if_addr = addr; end
            2: begin ia.dm_req = v; ia.dm_we = we; ia.dm_addr = addr; ia.dm_wdata = wd; end
            default: begin ia.ext_req = v; ia.ext_we = we; ia.ext_addr = addr; ia.ext_wdata = wd; end
        endcase
    endtask

    function automatic logic ack_a(input int id);
        case (id)
            1: return ia.if_ack;
            2: return ia.dm_ack;
            default: return ia.ext_ack;
        endcase
    endfunction

    function automatic logic [31:0] rdata_a(input int id);
        case (id)
            1: return ia.if_rdata;
            2: return ia.dm_rdata;
            default: return ia.ext_rdata;
        endcase
    endfunction

    // waits (bounded) for any ack on A; n = number of falling edges sampled, ack on the last
    task automatic wait_ack_a(output int who, output int n);
        who = 0;
        n   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ia.dm_ack) who = 2;
            else if (ia.if_ack) who = 1;
            else if (ia.ext_ack) who = 3;
            if (who != 0) begin
                n = i;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL wait_ack: no ack within 20 cycles");
    endtask

    typedef struct {
        int          id;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs [7];

    // random-phase model state
    logic [31:0] ref_mem [1024];
    logic        rq   [1:3];
    logic        rwe  [1:3];
    logic [9:0]  radr [1:3];
    logic [31:0] rwd  [1:3];
    logic [31:0] exp_rd [1:3];
    logic        acked [1:3];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, n, seen, strobes, acks;
        int next_free, arb_c, strb_c, ack_c, own, starve;
        logic        m_we;
        logic [9:0]  m_adr;
        logic [31:0] m_wd, m_rd;
        logic        busy_e;

        vecs[0] = '{1, 1'b0, 10'h004, 32'h0,        32'h3C010001};
        vecs[1] = '{2, 1'b1, 10'h010, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{2, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{3, 1'b1, 10'h3FF, 32'h12345678, 32'h0};
        vecs[4] = '{3, 1'b0, 10'h3FF, 32'h0,        32'h12345678};
        vecs[5] = '{1, 1'b0, 10'h3FF, 32'h0,        32'h12345678};
        vecs[6] = '{2, 1'b0, 10'h020, 32'h0,        32'hC0DE0020};

        rst_a = 1'b1; rst_b = 1'b1;
        for (int k = 1; k <= 3; k++) drive_a(k, 1'b0, 1'b0, 10'h0, 32'h0);
        ib.if_req = 0; ib.if_addr = 0; ib.dm_req = 0; ib.dm_we = 0; ib.dm_addr = 0; ib.dm_wdata = 0;
        ib.ext_req = 0; ib.ext_we = 0; ib.ext_addr = 0; ib.ext_wdata = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_a", ia.busy, 0);
        chk("rst_grant_a", ia.grant_id, 0);
        chk("rst_en_a", ia.mem_en, 0);
        chk("rst_we_a", ia.mem_we, 0);
        chk("rst_acks_a", {ia.if_ack, ia.dm_ack, ia.ext_ack}, 0);
        chk("rst_rdata_a", ia.if_rdata | ia.dm_rdata | ia.ext_rdata, 0);
        chk("rst_busy_b", ib.busy, 0);
        chk("rst_grant_b", ib.grant_id, 0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;

        // single-requester table on A (no wait states)
        for (int i = 0; i < 7; i++) begin
            drive_a(vecs[i].id, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("tbl%0d_idle", i), ia.busy, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("tbl%0d_en", i), ia.mem_en, 1);
            chk($sformatf("tbl%0d_we", i), ia.mem_we, vecs[i].we);
            chk($sformatf("tbl%0d_addr", i), ia.mem_addr, vecs[i].addr);
            chk($sformatf("tbl%0d_grant", i), ia.grant_id, vecs[i].id);
            if (vecs[i].we) chk($sformatf("tbl%0d_wdata", i), ia.mem_wdata, vecs[i].wdata);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("tbl%0d_ack", i), ack_a(vecs[i].id), 1);
            chk($sformatf("tbl%0d_en_off", i), ia.mem_en, 0);
            if (!vecs[i].we) chk($sformatf("tbl%0d_rdata", i), rdata_a(vecs[i].id), vecs[i].exp_rd);
            @(posedge clk); #1;
            drive_a(vecs[i].id, 1'b0, 1'b0, 10'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("tbl%0d_done", i), {ia.busy, ia.if_ack, ia.dm_ack, ia.ext_ack}, 0);
            @(posedge clk); #1;
        end

        // simultaneous dm and if: dm first, if in the following IDLE
        drive_a(2, 1'b1, 1'b0, 10'h020, 32'h0);
        drive_a(1, 1'b1, 1'b0, 10'h008, 32'h0);
        wait_ack_a(who, n);
        chk("pri_first", who, 2);
        chk("pri_first_lat", n, 3);
        chk("pri_first_grant", ia.grant_id, 2);
        chk("pri_first_rd", ia.dm_rdata, 32'hC0DE0020);
        @(posedge clk); #1;
        drive_a(2, 1'b0, 1'b0, 10'h0, 32'h0);
        wait_ack_a(who, n);
        chk("pri_second", who, 1);
        chk("pri_second_lat", n, 3);
        chk("pri_second_grant", ia.grant_id, 1);
        chk("pri_second_rd", ia.if_rdata, 32'hC0DE0008);
        chk("pri_dm_hold", ia.dm_rdata, 32'hC0DE0020);
        @(posedge clk); #1;
        drive_a(1, 1'b0, 1'b0, 10'h0, 32'h0);

        // starvation: ext held, dm held back-to-back; ext must win the third arbitration
        drive_a(3, 1'b1, 1'b1, 10'h030, 32'hCAFE0001);
        drive_a(2, 1'b1, 1'b0, 10'h040, 32'h0);
        for (int k = 0; k < 3; k++) begin
            wait_ack_a(who, n);
            chk($sformatf("starve_win%0d", k), who, (k < 2) ? 2 : 3);
            chk($sformatf("starve_lat%0d", k), n, 3);
            @(posedge clk); #1;
        end
        drive_a(2, 1'b0, 1'b0, 10'h0, 32'h0);
        drive_a(3, 1'b0, 1'b0, 10'h0, 32'h0);
        @(negedge clk);
        chk("starve_wr", mem_a[10'h030], 32'hCAFE0001);
        @(posedge clk); #1;

        // if_req held across its ack: exactly two accesses
        drive_a(1, 1'b1, 1'b0, 10'h005, 32'h0);
        strobes = 0; acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ia.mem_en) strobes++;
            if (ia.if_ack) begin
                acks++;
                chk("hold_rd", ia.if_rdata, init_word(5));
            end
            @(posedge clk); #1;
            if (acks == 2) drive_a(1, 1'b0, 1'b0, 10'h0, 32'h0);
        end
        chk("hold_strobes", strobes, 2);
        chk("hold_acks", acks, 2);

        // reset in the strobe cycle of an ext write
        drive_a(3, 1'b1, 1'b1, 10'h031, 32'h0BADF00D);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rma_we_before", ia.mem_we, 1);
        chk("rma_grant_before", ia.grant_id, 3);
        #1 rst_a = 1'b1;
        #1;
        chk("rma_we_async", ia.mem_we, 0);
        chk("rma_en_async", ia.mem_en, 0);
        chk("rma_busy_async", ia.busy, 0);
        chk("rma_grant_async", ia.grant_id, 0);
        drive_a(3, 1'b0, 1'b0, 10'h0, 32'h0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ia.ext_ack) seen++;
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("rma_no_ack", seen, 0);
        chk("rma_no_write", mem_a[10'h031], init_word(10'h031));
        chk("rma_if_rd_clr", ia.if_rdata, 0);
        chk("rma_dm_rd_clr", ia.dm_rdata, 0);
        @(posedge clk); #1;

        // WAIT_CYCLES=3 store on B: strobe at T+4, ack at T+5, busy T+1..T+5
        ib.dm_req = 1'b1; ib.dm_we = 1'b1; ib.dm_addr = 10'h010; ib.dm_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("w3_en%0d", k), ib.mem_en, (k == 4));
            chk($sformatf("w3_we%0d", k), ib.mem_we, (k == 4));
            chk($sformatf("w3_busy%0d", k), ib.busy, (k >= 1 && k <= 5));
            chk($sformatf("w3_ack%0d", k), ib.dm_ack, (k == 5));
            chk($sformatf("w3_grant%0d", k), ib.grant_id, (k >= 1 && k <= 5) ? 2 : 0);
            if (k == 4) chk("w3_addr", ib.mem_addr, 10'h010);
            @(posedge clk); #1;
            if (k == 5) ib.dm_req = 1'b0;
        end
        chk("w3_mem", mem_b[10'h010], 32'hDEADBEEF);

        // random traffic on A against a schedule model
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem_a[i];
        for (int k = 1; k <= 3; k++) begin
            rq[k] = 0; rwe[k] = 0; radr[k] = 0; rwd[k] = 0; exp_rd[k] = 0;
        end
        next_free = 0; arb_c = -1; strb_c = -1; ack_c = -1; own = 0; starve = 0;
        m_we = 0; m_adr = 0; m_wd = 0; m_rd = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == strb_c) begin
                if (m_we) ref_mem[m_adr] = m_wd;
                else      m_rd = ref_mem[m_adr];
            end
            if (c == ack_c && !m_we) exp_rd[own] = m_rd;
            busy_e = (c > arb_c) && (c <= ack_c);
            chk("rnd_busy", ia.busy, busy_e);
            chk("rnd_grant", ia.grant_id, busy_e ? own : 0);
            chk("rnd_en", ia.mem_en, (c == strb_c));
            chk("rnd_we", ia.mem_we, (c == strb_c) && m_we);
            if (c == strb_c) chk("rnd_addr", ia.mem_addr, m_adr);
            if (c == strb_c && m_we) chk("rnd_wdata", ia.mem_wdata, m_wd);
            for (int k = 1; k <= 3; k++) begin
                acked[k] = (c == ack_c) && (own == k);
                chk($sformatf("rnd_ack%0d", k), ack_a(k), acked[k]);
                chk($sformatf("rnd_rd%0d", k), rdata_a(k), exp_rd[k]);
            end
            if (c >= next_free && (rq[1] || rq[2] || rq[3])) begin
                if (rq[3] && starve == MA) own = 3;
                else if (rq[2])            own = 2;
                else if (rq[1])            own = 1;
                else                       own = 3;
                if (own == 3)    starve = 0;
                else if (rq[3])  starve = (starve < MA) ? starve + 1 : MA;
                m_we  = (own == 1) ? 1'b0 : rwe[own];
                m_adr = radr[own];
                m_wd  = rwd[own];
                arb_c = c; strb_c = c + 1 + WA; ack_c = c + 2 + WA; next_free = c + 3 + WA;
            end
            @(posedge clk); #1;
            for (int k = 1; k <= 3; k++) begin
                if (acked[k]) begin
                    if ($urandom_range(0, 3) != 0) rq[k] = 1'b0;
                end else if (!rq[k] && $urandom_range(0, 2) == 0) begin
                    rq[k]   = 1'b1;
                    rwe[k]  = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                    radr[k] = 10'($urandom_range(0, 15));
                    rwd[k]  = $urandom;
                end
                drive_a(k, rq[k], rwe[k], radr[k], rwd[k]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
